id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL expose: clock  in  1  rising-edge pipeline clock.
REQ-002 SHALL expose: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL expose: stall_id_ex  in  1  hold all ID/EX contents this edge.
REQ-004 SHALL expose: flush_id_ex  in  1  load a bubble this edge (branch/jump taken).
REQ-005 SHALL expose: ctrl_*_hazard_mux  in  1 each  ten control bits from the hazard mux (reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump, alu_op1, alu_op0).
REQ-006 SHALL expose: reg_1_content, reg_2_content, extension_out, pc_plus_4_if_id  in  32 each  ID-stage operands.
REQ-007 SHALL expose: instr_rs_if_id, instr_rt_if_id, instr_rd_if_id  in  5 each  register fields of the decoding instruction.
REQ-008 SHALL expose: matching registered outputs suffixed _id_ex (ten control bits, four 32-bit operands, three 5-bit fields), plus valid_id_ex  out  1.
REQ-009 SHALL expose: ctrl_hazard_mux_hazard  out  1  load-use stall request; pc_write, if_id_write  out  1 each  equal to its inverse.

Function
REQ-010 SHALL update registered state only on rising clock edges; outputs change one cycle after capture (latency 1).
REQ-011 Priority SHALL be flush_id_ex > stall_id_ex > normal load.
REQ-012 Normal load: all _id_ex outputs SHALL take the corresponding inputs; valid_id_ex <= 1.
REQ-013 Flush: all ten control outputs, all operand/field outputs and valid_id_ex SHALL be 0.
REQ-014 Stall without flush: every registered output SHALL hold its value.
REQ-015 ctrl_hazard_mux_hazard SHALL be combinational = valid_id_ex & ctrl_mem_read_id_ex & (instr_rt_id_ex != 0) & (instr_rt_id_ex == instr_rs_if_id | instr_rt_id_ex == instr_rt_if_id).
REQ-016 When hazard asserts, the zeroed controls from the hazard mux SHALL be captured as a normal load, so exactly one bubble enters EX; hazard SHALL then deassert next cycle since the bubble has mem_read 0.
REQ-017 Register $0 in rt SHALL never raise a hazard.
REQ-018 Simultaneous flush and hazard SHALL yield a bubble, hazard deasserting next cycle.
REQ-019 No internal counters; widths fixed, no arithmetic performed.

Reset
REQ-020 reset_n low SHALL immediately clear every registered output and valid_id_ex to 0, independent of clock.
REQ-021 ctrl_hazard_mux_hazard SHALL read 0 and pc_write/if_id_write 1 while in reset.
REQ-022 Reset asserted mid-stall or mid-flush SHALL override both; first edge after release performs a normal load per REQ-011.

Structure
REQ-023 Data width (32), register-field width (5) and control-bit count (10) SHALL live in the shared pipeline package.
REQ-024 Load-use comparison SHALL be one sub-module, load_use_detect, instantiated once; the register bank is in id_ex_stage itself.

Verification
REQ-025 Reset: reset_n=0 with all inputs 0xFFFFFFFF/1 -> all _id_ex outputs 0, valid 0, pc_write 1, asynchronously.
REQ-026 Load: reg_1_content=0x00000005, ctrl_reg_write=1, rt=9 -> next edge reg_1_content_id_ex=0x5, ctrl_reg_write_id_ex=1, instr_rt_id_ex=9, valid 1.
REQ-027 Load-use: lw with rt=8 in ID/EX, next instr rs=8 -> hazard=1, pc_write=0; next edge controls 0, hazard=0.
REQ-028 $0 case: lw rt=0 in ID/EX, next rs=0 -> hazard stays 0.
REQ-029 Stall+flush same edge with new data 0xABCD -> outputs 0, not 0xABCD and not held value.
REQ-030 Stall 3 cycles with changing inputs -> outputs constant for 3 cycles, new value loaded on 4th edge.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_pkg
//   Shared pipeline definitions for the ID/EX boundary: datapath width,
//   register-field width, control-bit count, the control-bundle and
//   pipeline-register record types, and the load-use match helper.
// -----------------------------------------------------------------------------
package id_ex_stage_pkg;

  localparam int DATA_W = 32;  // operand / PC width
  localparam int REG_W  = 5;   // register-file index width
  localparam int CTRL_N = 10;  // number of control bits carried into EX

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [REG_W-1:0]  reg_idx_t;

  // Control bundle produced by the hazard mux. Field order fixes the packed
  // layout (reg_dst is the MSB, alu_op0 the LSB).
  typedef struct packed {
    logic reg_dst;
    logic alu_src;
    logic mem_to_reg;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
    logic alu_op1;
    logic alu_op0;
  } ctrl_t;

  // Everything the ID/EX register holds. An all-zero record is a bubble.
  typedef struct packed {
    logic     valid;
    ctrl_t    ctrl;
    data_t    reg_1;
    data_t    reg_2;
    data_t    ext;
    data_t    pc_plus_4;
    reg_idx_t rs;
    reg_idx_t rt;
    reg_idx_t rd;
  } id_ex_t;

  // True when the EX-stage destination rt is a real register ($0 excluded)
  // and is read as a source by the instruction currently in decode.
  function automatic logic rt_matches(input reg_idx_t rt_ex,
                                      input reg_idx_t rs_id,
                                      input reg_idx_t rt_id);
    return (rt_ex != '0) && ((rt_ex == rs_id) || (rt_ex == rt_id));
  endfunction

endpackage : id_ex_stage_pkg

// File: rtl/id_ex_stage_load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
//   Combinational load-use hazard detector. Raises hazard when the
//   instruction in EX is a valid load whose rt feeds the instruction in ID.
//
//   Ports:
//     valid_id_ex     in  1      EX slot holds a real instruction
//     mem_read_id_ex  in  1      EX instruction is a load
//     rt_id_ex        in  REG_W  load destination register
//     rs_if_id        in  REG_W  decoding instruction source rs
//     rt_if_id        in  REG_W  decoding instruction source rt
//     hazard          out 1      stall request for PC / IF-ID
// -----------------------------------------------------------------------------
module load_use_detect
  import id_ex_stage_pkg::*;
(
  input  logic     valid_id_ex,
  input  logic     mem_read_id_ex,
  input  reg_idx_t rt_id_ex,
  input  reg_idx_t rs_if_id,
  input  reg_idx_t rt_if_id,
  output logic     hazard
);

  // valid gates the whole term so a flushed or reset slot can never stall.
  assign hazard = valid_id_ex & mem_read_id_ex &
                  rt_matches(rt_id_ex, rs_if_id, rt_if_id);

endmodule : load_use_detect

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register with stall/flush control and load-use hazard
//   detection. Captures the hazard-muxed control bits, decode operands and
//   register fields on each rising clock edge. flush loads a bubble and
//   overrides stall; stall holds every field.
//
//   Ports:
//     clock, reset_n                     rising-edge clock, async active-low reset
//     stall_id_ex, flush_id_ex           hold / bubble control
//     ctrl_*_hazard_mux (10)             control bits from the hazard mux
//     reg_1_content, reg_2_content,
//     extension_out, pc_plus_4_if_id     32-bit ID-stage operands
//     instr_rs/rt/rd_if_id               5-bit register fields in decode
//     *_id_ex                            registered copies of the above
//     valid_id_ex                        EX slot holds a real instruction
//     ctrl_hazard_mux_hazard             load-use stall request
//     pc_write, if_id_write              inverse of the stall request
// -----------------------------------------------------------------------------
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,

  input  logic              stall_id_ex,
  input  logic              flush_id_ex,

  input  logic              ctrl_reg_dst_hazard_mux,
  input  logic              ctrl_alu_src_hazard_mux,
  input  logic              ctrl_mem_to_reg_hazard_mux,
  input  logic              ctrl_reg_write_hazard_mux,
  input  logic              ctrl_mem_read_hazard_mux,
  input  logic              ctrl_mem_write_hazard_mux,
  input  logic              ctrl_branch_hazard_mux,
  input  logic              ctrl_jump_hazard_mux,
  input  logic              ctrl_alu_op1_hazard_mux,
  input  logic              ctrl_alu_op0_hazard_mux,

  input  logic [DATA_W-1:0] reg_1_content,
  input  logic [DATA_W-1:0] reg_2_content,
  input  logic [DATA_W-1:0] extension_out,
  input  logic [DATA_W-1:0] pc_plus_4_if_id,

  input  logic [REG_W-1:0]  instr_rs_if_id,
  input  logic [REG_W-1:0]  instr_rt_if_id,
  input  logic [REG_W-1:0]  instr_rd_if_id,

  output logic              ctrl_reg_dst_id_ex,
  output logic              ctrl_alu_src_id_ex,
  output logic              ctrl_mem_to_reg_id_ex,
  output logic              ctrl_reg_write_id_ex,
  output logic              ctrl_mem_read_id_ex,
  output logic              ctrl_mem_write_id_ex,
  output logic              ctrl_branch_id_ex,
  output logic              ctrl_jump_id_ex,
  output logic              ctrl_alu_op1_id_ex,
  output logic              ctrl_alu_op0_id_ex,

  output logic [DATA_W-1:0] reg_1_content_id_ex,
  output logic [DATA_W-1:0] reg_2_content_id_ex,
  output logic [DATA_W-1:0] extension_out_id_ex,
  output logic [DATA_W-1:0] pc_plus_4_id_ex,

  output logic [REG_W-1:0]  instr_rs_id_ex,
  output logic [REG_W-1:0]  instr_rt_id_ex,
  output logic [REG_W-1:0]  instr_rd_id_ex,

  output logic              valid_id_ex,

  output logic              ctrl_hazard_mux_hazard,
  output logic              pc_write,
  output logic              if_id_write
);

  ctrl_t  ctrl_in;
  id_ex_t bank_d;
  id_ex_t bank_q;
  logic   hazard;

  assign ctrl_in = '{
    reg_dst:    ctrl_reg_dst_hazard_mux,
    alu_src:    ctrl_alu_src_hazard_mux,
    mem_to_reg: ctrl_mem_to_reg_hazard_mux,
    reg_write:  ctrl_reg_write_hazard_mux,
    mem_read:   ctrl_mem_read_hazard_mux,
    mem_write:  ctrl_mem_write_hazard_mux,
    branch:     ctrl_branch_hazard_mux,
    jump:       ctrl_jump_hazard_mux,
    alu_op1:    ctrl_alu_op1_hazard_mux,
    alu_op0:    ctrl_alu_op0_hazard_mux
  };

  // Next-state: flush beats stall beats load. A load-use bubble needs no
  // special case here -- the hazard mux already zeroes the controls, so it
  // is captured as an ordinary load.
  always_comb begin
    // NOTE: the hold value is assigned first so every path drives bank_d and
    // no latch is inferred; combinational blocks use blocking '='.
    bank_d = bank_q;
    if (flush_id_ex) begin
      bank_d = '0;
    end else if (!stall_id_ex) begin
      bank_d.valid     = 1'b1;
      bank_d.ctrl      = ctrl_in;
      bank_d.reg_1     = reg_1_content;
      bank_d.reg_2     = reg_2_content;
      bank_d.ext       = extension_out;
      bank_d.pc_plus_4 = pc_plus_4_if_id;
      bank_d.rs        = instr_rs_if_id;
      bank_d.rt        = instr_rt_if_id;
      bank_d.rd        = instr_rd_if_id;
    end
  end

  // NOTE: the whole bank is reset (not only valid) because downstream logic
  // observes every field directly; sequential state uses non-blocking '<='.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bank_q <= '0;
    end else begin
      bank_q <= bank_d;
    end
  end

  assign ctrl_reg_dst_id_ex    = bank_q.ctrl.reg_dst;
  assign ctrl_alu_src_id_ex    = bank_q.ctrl.alu_src;
  assign ctrl_mem_to_reg_id_ex = bank_q.ctrl.mem_to_reg;
  assign ctrl_reg_write_id_ex  = bank_q.ctrl.reg_write;
  assign ctrl_mem_read_id_ex   = bank_q.ctrl.mem_read;
  assign ctrl_mem_write_id_ex  = bank_q.ctrl.mem_write;
  assign ctrl_branch_id_ex     = bank_q.ctrl.branch;
  assign ctrl_jump_id_ex       = bank_q.ctrl.jump;
  assign ctrl_alu_op1_id_ex    = bank_q.ctrl.alu_op1;
  assign ctrl_alu_op0_id_ex    = bank_q.ctrl.alu_op0;

  assign reg_1_content_id_ex   = bank_q.reg_1;
  assign reg_2_content_id_ex   = bank_q.reg_2;
  assign extension_out_id_ex   = bank_q.ext;
  assign pc_plus_4_id_ex       = bank_q.pc_plus_4;

  assign instr_rs_id_ex        = bank_q.rs;
  assign instr_rt_id_ex        = bank_q.rt;
  assign instr_rd_id_ex        = bank_q.rd;

  assign valid_id_ex           = bank_q.valid;

  load_use_detect u_load_use_detect (
    .valid_id_ex    (bank_q.valid),
    .mem_read_id_ex (bank_q.ctrl.mem_read),
    .rt_id_ex       (bank_q.rt),
    .rs_if_id       (instr_rs_if_id),
    .rt_if_id       (instr_rt_if_id),
    .hazard         (hazard)
  );

  // While in reset valid is 0, so hazard is 0 and both write enables are 1.
  assign ctrl_hazard_mux_hazard = hazard;
  assign pc_write               = ~hazard;
  assign if_id_write            = ~hazard;

endmodule : id_ex_stage

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//   Directed scenarios followed by randomized traffic for id_ex_stage, each
//   output compared against a transaction-level model of the ID/EX slot.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

  localparam int MR = 5;  // mem_read position in the packed control vector

  logic        clock;
  logic        reset_n;
  logic        stall;
  logic        flush;
  logic [9:0]  ctrl_in;   // {reg_dst..alu_op0}, reg_dst is bit 9
  logic [31:0] r1_in, r2_in, ext_in, pc_in;
  logic [4:0]  rs_in, rt_in, rd_in;

  logic [9:0]  ctrl_out;
  logic [31:0] r1_out, r2_out, ext_out, pc_out;
  logic [4:0]  rs_out, rt_out, rd_out;
  logic        valid_out, hazard_out, pc_write_out, if_id_write_out;

  // Reference model: the single instruction slot sitting in EX.
  typedef struct {
    bit          valid;
    bit   [9:0]  ctrl;
    bit   [31:0] r1, r2, ext, pc;
    bit   [4:0]  rs, rt, rd;
  } slot_t;

  slot_t m;
  int    total = 0;
  int    bad   = 0;

  id_ex_stage dut (
    .clock                      (clock),
    .reset_n                    (reset_n),
    .stall_id_ex                (stall),
    .flush_id_ex                (flush),
    .ctrl_reg_dst_hazard_mux    (ctrl_in[9]),
    .ctrl_alu_src_hazard_mux    (ctrl_in[8]),
    .ctrl_mem_to_reg_hazard_mux (ctrl_in[7]),
    .ctrl_reg_write_hazard_mux  (ctrl_in[6]),
    .ctrl_mem_read_hazard_mux   (ctrl_in[5]),
    .ctrl_mem_write_hazard_mux  (ctrl_in[4]),
    .ctrl_branch_hazard_mux     (ctrl_in[3]),
    .ctrl_jump_hazard_mux       (ctrl_in[2]),
    .ctrl_alu_op1_hazard_mux    (ctrl_in[1]),
    .ctrl_alu_op0_hazard_mux    (ctrl_in[0]),
    .reg_1_content              (r1_in),
    .reg_2_content              (r2_in),
    .extension_out              (ext_in),
    .pc_plus_4_if_id            (pc_in),
    .instr_rs_if_id             (rs_in),
    .instr_rt_if_id             (rt_in),
    .instr_rd_if_id             (rd_in),
    .ctrl_reg_dst_id_ex         (ctrl_out[9]),
    .ctrl_alu_src_id_ex         (ctrl_out[8]),
    .ctrl_mem_to_reg_id_ex      (ctrl_out[7]),
    .ctrl_reg_write_id_ex       (ctrl_out[6]),
    .ctrl_mem_read_id_ex        (ctrl_out[5]),
    .ctrl_mem_write_id_ex       (ctrl_out[4]),
    .ctrl_branch_id_ex          (ctrl_out[3]),
    .ctrl_jump_id_ex            (ctrl_out[2]),
    .ctrl_alu_op1_id_ex         (ctrl_out[1]),
    .ctrl_alu_op0_id_ex         (ctrl_out[0]),
    .reg_1_content_id_ex        (r1_out),
    .reg_2_content_id_ex        (r2_out),
    .extension_out_id_ex        (ext_out),
    .pc_plus_4_id_ex            (pc_out),
    .instr_rs_id_ex             (rs_out),
    .instr_rt_id_ex             (rt_out),
    .instr_rd_id_ex             (rd_out),
    .valid_id_ex                (valid_out),
    .ctrl_hazard_mux_hazard     (hazard_out),
    .pc_write                   (pc_write_out),
    .if_id_write                (if_id_write_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // A load in EX whose destination (never $0) is read by the decoding instruction.
  function automatic bit model_hazard();
    return m.valid && m.ctrl[MR] && (m.rt != 5'd0) && (m.rt == rs_in || m.rt == rt_in);
  endfunction

  // What the slot becomes after one rising edge.
  function automatic void model_edge();
    if (!reset_n) begin
      m = '{default: '0};
    end else if (flush) begin
      m = '{default: '0};
    end else if (!stall) begin
      m = '{valid: 1'b1, ctrl: ctrl_in, r1: r1_in, r2: r2_in, ext: ext_in,
            pc: pc_in, rs: rs_in, rt: rt_in, rd: rd_in};
    end
  endfunction

  task automatic check_all(input string t);
    bit h;
    h = model_hazard();
    check({t, ".ctrl"},  {22'd0, ctrl_out}, {22'd0, m.ctrl});
    check({t, ".r1"},    r1_out,  m.r1);
    check({t, ".r2"},    r2_out,  m.r2);
    check({t, ".ext"},   ext_out, m.ext);
    check({t, ".pc4"},   pc_out,  m.pc);
    check({t, ".rs"},    {27'd0, rs_out}, {27'd0, m.rs});
    check({t, ".rt"},    {27'd0, rt_out}, {27'd0, m.rt});
    check({t, ".rd"},    {27'd0, rd_out}, {27'd0, m.rd});
    check({t, ".valid"}, {31'd0, valid_out},       {31'd0, m.valid});
    check({t, ".haz"},   {31'd0, hazard_out},      {31'd0, h});
    check({t, ".pcw"},   {31'd0, pc_write_out},    {31'd0, ~h});
    check({t, ".ifidw"}, {31'd0, if_id_write_out}, {31'd0, ~h});
  endtask

  task automatic drive(input logic [9:0] c, input logic [31:0] r1, input logic [4:0] rs,
                       input logic [4:0] rt, input logic s, input logic f);
    ctrl_in = c;  r1_in = r1;  r2_in = r1 ^ 32'h5A5A_0000;
    ext_in  = ~r1; pc_in = r1 + 32'd4;
    rs_in = rs;  rt_in = rt;  rd_in = rs ^ rt;
    stall = s;   flush = f;
  endtask

  // One rising edge, then compare 1 time unit later.
  task automatic tick(input string t);
    @(posedge clock);
    model_edge();
    #1;
    check_all(t);
  endtask

  initial begin
    logic [31:0] held;

    // Reset with every input at all-ones.
    reset_n = 1'b0;
    drive(10'h3FF, 32'hFFFF_FFFF, 5'h1F, 5'h1F, 1'b1, 1'b1);
    m = '{default: '0};
    #2;
    check_all("reset");
    check("reset.pcw1", {31'd0, pc_write_out}, 32'd1);

    // Release mid-cycle, load the all-ones word, then assert reset without a clock edge.
    @(negedge clock);
    reset_n = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    tick("load_ones");
    check("load_ones.haz_set", {31'd0, hazard_out}, 32'd1);
    #2;
    reset_n = 1'b0;
    m = '{default: '0};
    #1;
    check_all("async_reset");
    @(negedge clock);
    reset_n = 1'b1;

    // Plain load: reg_1_content=5, reg_write=1, rt=9.
    drive(10'b0001000000, 32'h0000_0005, 5'd3, 5'd9, 1'b0, 1'b0);
    tick("load");
    check("load.r1", r1_out, 32'h5);
    check("load.rt", {27'd0, rt_out}, 32'd9);
    check("load.regw", {31'd0, ctrl_out[6]}, 32'd1);

    // Load-use: lw rt=8, then decode reads rs=8.
    drive(10'b0011100000, 32'h0000_0100, 5'd1, 5'd8, 1'b0, 1'b0);
    tick("lw8");
    drive(10'b0001000000, 32'h0000_0200, 5'd8, 5'd2, 1'b0, 1'b0);
    #1;
    check_all("lu_detect");
    check("lu.haz", {31'd0, hazard_out}, 32'd1);
    check("lu.pcw", {31'd0, pc_write_out}, 32'd0);
    ctrl_in = 10'd0;  // hazard mux substitutes zeroed controls
    tick("lu_bubble");
    check("lu_bubble.ctrl", {22'd0, ctrl_out}, 32'd0);
    check("lu_bubble.haz", {31'd0, hazard_out}, 32'd0);

    // $0 destination never stalls.
    drive(10'b0011100000, 32'h0000_0300, 5'd4, 5'd0, 1'b0, 1'b0);
    tick("lw0");
    drive(10'b0001000000, 32'h0000_0400, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    check("zero.haz", {31'd0, hazard_out}, 32'd0);

    // Flush and hazard together: bubble, hazard drops.
    drive(10'b0011100000, 32'h0000_0500, 5'd4, 5'd7, 1'b0, 1'b0);
    tick("lw7");
    drive(10'b0000000000, 32'h0000_0600, 5'd7, 5'd1, 1'b0, 1'b1);
    #1;
    check("fh.haz", {31'd0, hazard_out}, 32'd1);
    tick("flush_hazard");
    check("fh.haz_after", {31'd0, hazard_out}, 32'd0);

    // Stall and flush on the same edge with new data 0xABCD.
    drive(10'b1100000011, 32'h0000_1234, 5'd2, 5'd3, 1'b0, 1'b0);
    tick("pre_sf");
    drive(10'b1111111111, 32'h0000_ABCD, 5'd5, 5'd6, 1'b1, 1'b1);
    tick("stall_flush");
    check("stall_flush.r1", r1_out, 32'h0);

    // Three stalled edges with changing inputs, new value on the fourth.
    drive(10'b0100000101, 32'h0000_7777, 5'd10, 5'd11, 1'b0, 1'b0);
    tick("pre_stall");
    held = r1_out;
    for (int i = 0; i < 3; i++) begin
      drive(10'b1010101010, 32'h0000_9000 + i, 5'd12, 5'd13, 1'b1, 1'b0);
      tick("stall3");
      check("stall3.r1", r1_out, 32'h0000_7777);
    end
    drive(10'b0000000001, 32'h0000_8888, 5'd14, 5'd15, 1'b0, 1'b0);
    tick("stall_release");
    check("stall_release.r1", r1_out, 32'h0000_8888);
    check("stall_release.changed", {31'd0, r1_out != held}, 32'd1);

    // Reset during stall+flush, then a normal load after release.
    drive(10'b1111111111, 32'h0000_4444, 5'd1, 5'd2, 1'b1, 1'b1);
    #2;
    reset_n = 1'b0;
    m = '{default: '0};
    tick("reset_in_stall");
    @(negedge clock);
    reset_n = 1'b1;
    drive(10'b0000000110, 32'h0000_5555, 5'd3, 5'd4, 1'b0, 1'b0);
    tick("post_reset_load");

    // Randomized traffic; the hazard mux is emulated by zeroing controls.
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clock);
      ctrl_in = 10'($urandom);
      if ($urandom_range(0, 2) == 0) ctrl_in[MR] = 1'b1;
      r1_in  = $urandom;
      r2_in  = $urandom;
      ext_in = $urandom;
      pc_in  = $urandom;
      rs_in  = 5'($urandom_range(0, 3));
      rt_in  = 5'($urandom_range(0, 3));
      rd_in  = 5'($urandom);
      stall  = ($urandom_range(0, 5) == 0);
      flush  = ($urandom_range(0, 7) == 0);
      if (model_hazard()) ctrl_in = 10'd0;
      #1;
      check_all("rand_comb");
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_id_ex_stage
